mealy_frame_sched: RTL and testbench

Frame scheduler that shares one `mealy_project` serial sequence detector between two requesters. Each requester hands over a WIDTH-bit parallel frame. The scheduler arbitrates round-robin, clears the detector, shifts the frame MSB-first into the detector's `x_in`, counts the detector's `y_out` pulses, and returns the count with a done strobe. It sits between the frame sources and the single detector instance, and is the only block that drives the detector's input and reset.

---
 rtl/mealy_frame_sched.sv | 157 +++++++++++++++
 tb/tb_mealy_frame_sched.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mealy_frame_sched.sv
`default_nettype none
// ============================================================================
// mealy_frame_sched : round-robin frame scheduler feeding one serial detector
// Rev 1.0
// ============================================================================
module mealy_frame_sched #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             det_x,
    output logic             det_rst_n,
    input  logic             det_y,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int               IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_INIT = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CLEAR  = 2'd1,
        S_SHIFT  = 2'd2,
        S_REPORT = 2'd3
    } state_t;

    state_t            r_state,     w_state_nxt;
    logic [WIDTH-1:0]  r_frame,     w_frame_nxt;
    logic [IDX_W-1:0]  r_idx,       w_idx_nxt;
    logic              r_owner,     w_owner_nxt;
    logic              r_last,      w_last_nxt;
    logic              r_gnt0,      w_gnt0_nxt;
    logic              r_gnt1,      w_gnt1_nxt;
    logic              r_det_x,     w_det_x_nxt;
    logic              r_det_rst_n, w_det_rst_n_nxt;
    logic              r_busy,      w_busy_nxt;
    logic              r_done,      w_done_nxt;
    logic              r_done_id,   w_done_id_nxt;
    logic [CNT_W-1:0]  r_cnt,       w_cnt_nxt;
    logic              w_pick;
    logic [IDX_W-1:0]  w_idx_dec;

    // Requester 1 wins when alone, or on a tie when requester 0 was served last.
    assign w_pick    = req1 & (~req0 | ~r_last);
    assign w_idx_dec = r_idx - IDX_W'(1);

    always_comb begin
        w_state_nxt     = r_state;
        w_frame_nxt     = r_frame;
        w_idx_nxt       = r_idx;
        w_owner_nxt     = r_owner;
        w_last_nxt      = r_last;
        w_gnt0_nxt      = 1'b0;
        w_gnt1_nxt      = 1'b0;
        w_det_x_nxt     = 1'b0;
        w_det_rst_n_nxt = r_det_rst_n;
        w_done_nxt      = 1'b0;
        w_done_id_nxt   = r_done_id;
        w_cnt_nxt       = r_cnt;

        case (r_state)
            S_IDLE: begin
                if (req0 || req1) begin
                    w_state_nxt     = S_CLEAR;
                    w_owner_nxt     = w_pick;
                    w_last_nxt      = w_pick;
                    w_frame_nxt     = w_pick ? data1 : data0;
                    w_gnt0_nxt      = ~w_pick;
                    w_gnt1_nxt      = w_pick;
                    w_det_rst_n_nxt = 1'b0;
                    w_cnt_nxt       = '0;
                    w_idx_nxt       = IDX_INIT;
                end
            end
            S_CLEAR: begin
                w_state_nxt     = S_SHIFT;
                w_det_rst_n_nxt = 1'b1;
                w_det_x_nxt     = r_frame[r_idx];
            end
            S_SHIFT: begin
                if (det_y && (r_cnt != CNT_MAX)) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
                if (r_idx == '0) begin
                    w_state_nxt   = S_REPORT;
                    w_done_nxt    = 1'b1;
                    w_done_id_nxt = r_owner;
                end else begin
                    w_idx_nxt   = w_idx_dec;
                    w_det_x_nxt = r_frame[w_idx_dec];
                end
            end
            S_REPORT: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_frame     <= '0;
            r_idx       <= '0;
            r_owner     <= 1'b0;
            r_last      <= 1'b1;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_det_x     <= 1'b0;
            r_det_rst_n <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_done_id   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_frame     <= w_frame_nxt;
            r_idx       <= w_idx_nxt;
            r_owner     <= w_owner_nxt;
            r_last      <= w_last_nxt;
            r_gnt0      <= w_gnt0_nxt;
            r_gnt1      <= w_gnt1_nxt;
            r_det_x     <= w_det_x_nxt;
            r_det_rst_n <= w_det_rst_n_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_done_id   <= w_done_id_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    assign gnt0      = r_gnt0;
    assign gnt1      = r_gnt1;
    assign det_x     = r_det_x;
    assign det_rst_n = r_det_rst_n;
    assign busy      = r_busy;
    assign done      = r_done;
    assign done_id   = r_done_id;
    assign match_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mealy_frame_sched.sv
`default_nettype none
// ============================================================================
// tb_mealy_frame_sched : directed + randomized bench with a frame-level model
// Rev 1.0
// ============================================================================
module tb_mealy_frame_sched;

    localparam int W    = 8;
    localparam int CW   = 2;
    localparam int MAXC = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          req0  = 1'b0;
    logic          req1  = 1'b0;
    logic          det_y = 1'b0;
    logic [W-1:0]  data0 = '0;
    logic [W-1:0]  data1 = '0;
    logic          gnt0, gnt1, det_x, det_rst_n, busy, done, done_id;
    logic [CW-1:0] match_cnt;

    mealy_frame_sched #(.WIDTH(W), .CNT_W(CW)) dut (
        .clock     (clock),
        .reset     (reset),
        .req0      (req0),
        .data0     (data0),
        .req1      (req1),
        .data1     (data1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .det_x     (det_x),
        .det_rst_n (det_rst_n),
        .det_y     (det_y),
        .busy      (busy),
        .done      (done),
        .done_id   (done_id),
        .match_cnt (match_cnt)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: pos is the cycle number inside a frame
    // (0 idle, 1 clear, 2..W+1 shift bits, W+2 report).
    int           pos = 0;
    int           m_cnt = 0;
    bit           m_owner = 1'b0;
    bit           m_last = 1'b1;
    bit           m_done_id = 1'b0;
    bit           m_idle_rstn = 1'b0;
    bit           started = 1'b0;
    logic [W-1:0] m_frame = '0;

    always @(posedge clock) begin
        if (!reset) begin
            started     = 1'b1;
            pos         = 0;
            m_last      = 1'b1;
            m_cnt       = 0;
            m_done_id   = 1'b0;
            m_idle_rstn = 1'b0;
        end else if (pos == 0) begin
            if (req0 || req1) begin
                m_owner = (req0 && req1) ? !m_last : req1;
                m_frame = m_owner ? data1 : data0;
                m_last  = m_owner;
                m_cnt   = 0;
                pos     = 1;
            end
        end else if (pos <= W + 1) begin
            if (pos >= 2 && det_y && m_cnt < MAXC) m_cnt++;
            pos++;
            if (pos == W + 2) m_done_id = m_owner;
        end else begin
            pos         = 0;
            m_idle_rstn = 1'b1;
        end
    end

    always @(negedge clock) begin
        if (started) begin
            chk("busy", 32'(busy), 32'(pos != 0));
            chk("gnt0", 32'(gnt0), 32'(pos == 1 && !m_owner));
            chk("gnt1", 32'(gnt1), 32'(pos == 1 && m_owner));
            chk("done", 32'(done), 32'(pos == W + 2));
            chk("det_x", 32'(det_x), 32'((pos >= 2 && pos <= W + 1) ? m_frame[W + 1 - pos] : 1'b0));
            chk("det_rst_n", 32'(det_rst_n), 32'((pos == 0) ? m_idle_rstn : (pos != 1)));
            chk("match_cnt", 32'(match_cnt), 32'(m_cnt));
            if (pos == 0 || pos == W + 2) chk("done_id", 32'(done_id), 32'(m_done_id));
        end
    end

    // det_y source: 0 random, 1 pulses on shift cycles 3 and 7, 2 always high,
    // 3 high only outside the shift window.
    int ymode = 0;

    task automatic cyc();
        @(negedge clock);
        case (ymode)
            1:       det_y = (pos - 1 == 3) || (pos - 1 == 7);
            2:       det_y = 1'b1;
            3:       det_y = !(pos >= 2 && pos <= W + 1);
            default: det_y = 1'($urandom_range(0, 1));
        endcase
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle();
        req0 = 1'b0;
        req1 = 1'b0;
        for (int i = 0; i < 40 && (busy || pos != 0); i++) cyc();
        chk("idle_timeout", 32'(busy), 32'(0));
    endtask

    task automatic do_frame(input bit who, input logic [W-1:0] d,
                            output logic [W-1:0] xs, output logic [CW-1:0] cnt,
                            output logic id);
        xs = '0;
        if (who) begin req1 = 1'b1; data1 = d; end
        else     begin req0 = 1'b1; data0 = d; end
        cyc();
        chk("frame_gnt", 32'(who ? gnt1 : gnt0), 32'(1));
        req0 = 1'b0;
        req1 = 1'b0;
        for (int c = 0; c < W; c++) begin
            cyc();
            xs = {xs[W-2:0], det_x};
        end
        cyc();
        chk("frame_done", 32'(done), 32'(1));
        cnt = match_cnt;
        id  = done_id;
    endtask

    logic [W-1:0]  xs;
    logic [CW-1:0] cnt;
    logic          id;
    int            g_who[$];
    int            g_time[$];
    int            d_id[$];

    initial begin
        // Reset held with a pending request: nothing may be granted.
        reset = 1'b0;
        req0  = 1'b1;
        data0 = W'($urandom);
        repeat (3) cyc();
        chk("rst_gnt0", 32'(gnt0), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_det_rst_n", 32'(det_rst_n), 32'(0));
        reset = 1'b1;
        cyc();
        chk("release_gnt0", 32'(gnt0), 32'(1));
        wait_idle();

        // Single frame: 1011_0110 with det_y on shift cycles 3 and 7.
        ymode = 1;
        do_frame(1'b0, 8'b1011_0110, xs, cnt, id);
        chk("single_det_x_seq", 32'(xs), 32'(8'b1011_0110));
        chk("single_match_cnt", 32'(cnt), 32'(2));
        chk("single_done_id", 32'(id), 32'(0));
        wait_idle();

        // Saturation: det_y high for every shift cycle.
        ymode = 2;
        do_frame(1'b1, W'($urandom), xs, cnt, id);
        chk("sat_match_cnt", 32'(cnt), 32'(3));
        chk("sat_done_id", 32'(id), 32'(1));
        wait_idle();

        // det_y only outside the shift window is ignored.
        ymode = 3;
        do_frame(1'b0, W'($urandom), xs, cnt, id);
        chk("outside_match_cnt", 32'(cnt), 32'(0));
        wait_idle();

        // Contention from reset release with both requesters streaming.
        ymode = 0;
        reset = 1'b0;
        req0  = 1'b1;
        req1  = 1'b1;
        data0 = W'($urandom);
        data1 = W'($urandom);
        cyc();
        cyc();
        reset = 1'b1;
        for (int n = 0; n < 40; n++) begin
            cyc();
            if (gnt0 || gnt1) begin g_who.push_back(int'(gnt1)); g_time.push_back(n); end
            if (done) d_id.push_back(int'(done_id));
        end
        chk("cont_grants", 32'(g_who.size() >= 3), 32'(1));
        chk("cont_dones", 32'(d_id.size() >= 3), 32'(1));
        if (g_who.size() >= 3 && d_id.size() >= 3) begin
            chk("cont_order0", 32'(g_who[0]), 32'(0));
            chk("cont_order1", 32'(g_who[1]), 32'(1));
            chk("cont_order2", 32'(g_who[2]), 32'(0));
            chk("cont_gap01", 32'(g_time[1] - g_time[0]), 32'(11));
            chk("cont_gap12", 32'(g_time[2] - g_time[1]), 32'(11));
            chk("cont_id0", 32'(d_id[0]), 32'(0));
            chk("cont_id1", 32'(d_id[1]), 32'(1));
            chk("cont_id2", 32'(d_id[2]), 32'(0));
        end
        wait_idle();

        // Mid-frame reset during the 4th shift cycle of a requester-0 frame.
        req0  = 1'b1;
        data0 = W'($urandom);
        cyc();
        req0 = 1'b0;
        repeat (4) cyc();
        chk("mid_in_shift4", 32'(pos), 32'(5));
        reset = 1'b0;
        req0  = 1'b1;
        req1  = 1'b1;
        cyc();
        chk("mid_busy", 32'(busy), 32'(0));
        chk("mid_det_rst_n", 32'(det_rst_n), 32'(0));
        chk("mid_done", 32'(done), 32'(0));
        cyc();
        reset = 1'b1;
        cyc();
        // Pointer is back at 1, so the tie goes to requester 0 again.
        chk("mid_tie_gnt0", 32'(gnt0), 32'(1));
        chk("mid_tie_gnt1", 32'(gnt1), 32'(0));
        req0 = 1'b0;
        for (int n = 0; n < 30 && !gnt1; n++) cyc();
        chk("mid_then_gnt1", 32'(gnt1), 32'(1));
        wait_idle();

        // Randomized traffic with occasional resets and drops.
        for (int n = 0; n < 500; n++) begin
            if (pos == 1) begin
                if (!m_owner && $urandom_range(0, 3) != 0) req0 = 1'b0;
                if (m_owner && $urandom_range(0, 3) != 0) req1 = 1'b0;
            end else begin
                if (!req0 && $urandom_range(0, 2) == 0) begin req0 = 1'b1; data0 = W'($urandom); end
                if (!req1 && $urandom_range(0, 2) == 0) begin req1 = 1'b1; data1 = W'($urandom); end
                if (req0 && pos != 0 && $urandom_range(0, 15) == 0) req0 = 1'b0;
            end
            if ($urandom_range(0, 15) == 0) ymode = $urandom_range(0, 3);
            reset = ($urandom_range(0, 199) != 0);
            cyc();
        end
        reset = 1'b1;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
